// File: rtl/membus_arbiter.sv
// membus_arbiter: shares one memory bus between m0 (SPI bridge) and m1 (sample sequencer).
// Latency: strobe -> bus strobe 2 cycles when idle; read strobe -> rvalid 2 + READ_LAT + 1 cycles.
// Backpressure: 1-deep slot per master; busy while occupied; strobes while busy are dropped and set sticky ovf.
// Ports:
//   clk_i, rst_i                        clock, synchronous active-high reset
//   mN_read_req_i/_write_req_i          one-cycle request strobes (N = 0, 1)
//   mN_addr_i/_data_i                   address / write data, sampled with the strobe
//   mN_busy_o, mN_ovf_o                 slot occupied, sticky dropped-strobe flag
//   mN_data_o, mN_rvalid_o, mN_wack_o   read data + one-cycle valid, one-cycle write ack
//   membus_*                            shared bus strobes, address, write data, read data
module membus_arbiter #(
  parameter int ADDR_W   = 7,
  parameter int DATA_W   = 8,
  parameter int READ_LAT = 1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              m0_read_req_i,
  input  logic              m0_write_req_i,
  input  logic [ADDR_W-1:0] m0_addr_i,
  input  logic [DATA_W-1:0] m0_data_i,
  output logic              m0_busy_o,
  output logic [DATA_W-1:0] m0_data_o,
  output logic              m0_rvalid_o,
  output logic              m0_wack_o,
  output logic              m0_ovf_o,
  input  logic              m1_read_req_i,
  input  logic              m1_write_req_i,
  input  logic [ADDR_W-1:0] m1_addr_i,
  input  logic [DATA_W-1:0] m1_data_i,
  output logic              m1_busy_o,
  output logic [DATA_W-1:0] m1_data_o,
  output logic              m1_rvalid_o,
  output logic              m1_wack_o,
  output logic              m1_ovf_o,
  output logic              membus_read_req_o,
  output logic              membus_write_req_o,
  output logic [ADDR_W-1:0] membus_addr_o,
  output logic [DATA_W-1:0] membus_data_o,
  input  logic [DATA_W-1:0] membus_data_i
);

  localparam int CNT_W = (READ_LAT > 1) ? $clog2(READ_LAT) : 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2
  } state_t;

  state_t r_state, w_state_nxt;

  logic [1:0]        w_rd_req, w_wr_req, w_stb;
  logic [ADDR_W-1:0] w_addr_in [2];
  logic [DATA_W-1:0] w_data_in [2];
  logic              w_gnt;

  logic [1:0]        r_pend, r_pend_rd, r_ovf, r_rvalid;
  logic [ADDR_W-1:0] r_slot_addr [2];
  logic [DATA_W-1:0] r_slot_data [2];
  logic [DATA_W-1:0] r_rdata [2];
  logic              r_gnt, r_is_rd, r_last;
  logic [ADDR_W-1:0] r_bus_addr;
  logic [DATA_W-1:0] r_bus_data;
  logic [CNT_W-1:0]  r_cnt;

  assign w_rd_req     = {m1_read_req_i, m0_read_req_i};
  assign w_wr_req     = {m1_write_req_i, m0_write_req_i};
  assign w_stb        = w_rd_req | w_wr_req;
  assign w_addr_in[0] = m0_addr_i;
  assign w_addr_in[1] = m1_addr_i;
  assign w_data_in[0] = m0_data_i;
  assign w_data_in[1] = m1_data_i;

  // Sole requester wins; on a tie the master not granted last time wins.
  always_comb begin
    w_gnt = r_pend[1];
    if (r_pend == 2'b11) w_gnt = ~r_last;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE:  if (|r_pend) w_state_nxt = S_ISSUE;
      S_ISSUE: w_state_nxt = r_is_rd ? S_WAIT : S_IDLE;
      S_WAIT:  if (r_cnt == '0) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_pend     <= '0;
      r_pend_rd  <= '0;
      r_ovf      <= '0;
      r_rvalid   <= '0;
      r_gnt      <= 1'b0;
      r_is_rd    <= 1'b0;
      r_last     <= 1'b1;  // so the first tie goes to m0
      r_bus_addr <= '0;
      r_bus_data <= '0;
      r_cnt      <= '0;
      for (int i = 0; i < 2; i++) begin
        r_slot_addr[i] <= '0;
        r_slot_data[i] <= '0;
        r_rdata[i]     <= '0;
      end
    end else begin
      r_rvalid <= '0;

      // Slot capture. The slot being issued is still marked pending during
      // ISSUE, so a strobe in that cycle lands in the overflow path.
      for (int i = 0; i < 2; i++) begin
        if (w_stb[i]) begin
          if (r_pend[i]) begin
            r_ovf[i] <= 1'b1;
          end else begin
            r_pend[i]      <= 1'b1;
            r_pend_rd[i]   <= w_rd_req[i];  // read wins over a simultaneous write
            r_slot_addr[i] <= w_addr_in[i];
            r_slot_data[i] <= w_data_in[i];
          end
        end
      end

      // Grant: latch the winning slot onto the bus registers so addr/data
      // hold their value after the ISSUE cycle.
      if (r_state == S_IDLE && |r_pend) begin
        r_gnt      <= w_gnt;
        r_is_rd    <= r_pend_rd[w_gnt];
        r_bus_addr <= r_slot_addr[w_gnt];
        r_bus_data <= r_slot_data[w_gnt];
      end

      if (r_state == S_ISSUE) begin
        r_pend[r_gnt] <= 1'b0;
        r_last        <= r_gnt;
        if (r_is_rd) r_cnt <= CNT_W'(READ_LAT - 1);
      end

      if (r_state == S_WAIT) begin
        if (r_cnt == '0) begin
          r_rdata[r_gnt]  <= membus_data_i;
          r_rvalid[r_gnt] <= 1'b1;
        end else begin
          r_cnt <= r_cnt - 1'b1;
        end
      end
    end
  end

  assign membus_read_req_o  = (r_state == S_ISSUE) && r_is_rd;
  assign membus_write_req_o = (r_state == S_ISSUE) && !r_is_rd;
  assign membus_addr_o      = r_bus_addr;
  assign membus_data_o      = r_bus_data;

  assign m0_busy_o   = r_pend[0];
  assign m1_busy_o   = r_pend[1];
  assign m0_ovf_o    = r_ovf[0];
  assign m1_ovf_o    = r_ovf[1];
  assign m0_rvalid_o = r_rvalid[0];
  assign m1_rvalid_o = r_rvalid[1];
  assign m0_data_o   = r_rdata[0];
  assign m1_data_o   = r_rdata[1];
  assign m0_wack_o   = membus_write_req_o && !r_gnt;
  assign m1_wack_o   = membus_write_req_o && r_gnt;

endmodule

// File: tb/tb_membus_arbiter.sv
// tb_membus_arbiter: scoreboard bench for membus_arbiter with a READ_LAT=1 slave model.
// Expected bus accesses and read returns are queued as stimulus is driven, popped on DUT output.
// Inputs change 1 ns after the rising edge; outputs are sampled on the falling edge.
module tb_membus_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic       m0_rd, m0_wr, m1_rd, m1_wr;
  logic [6:0] m0_a, m1_a;
  logic [7:0] m0_d, m1_d;
  logic       m0_busy, m0_rvalid, m0_wack, m0_ovf;
  logic       m1_busy, m1_rvalid, m1_wack, m1_ovf;
  logic [7:0] m0_q, m1_q;
  logic       bus_rd, bus_wr;
  logic [6:0] bus_a;
  logic [7:0] bus_wd, bus_rd_dat;

  always #5 clk = ~clk;

  membus_arbiter #(.ADDR_W(7), .DATA_W(8), .READ_LAT(1)) dut (
    .clk_i(clk), .rst_i(rst),
    .m0_read_req_i(m0_rd), .m0_write_req_i(m0_wr), .m0_addr_i(m0_a), .m0_data_i(m0_d),
    .m0_busy_o(m0_busy), .m0_data_o(m0_q), .m0_rvalid_o(m0_rvalid), .m0_wack_o(m0_wack), .m0_ovf_o(m0_ovf),
    .m1_read_req_i(m1_rd), .m1_write_req_i(m1_wr), .m1_addr_i(m1_a), .m1_data_i(m1_d),
    .m1_busy_o(m1_busy), .m1_data_o(m1_q), .m1_rvalid_o(m1_rvalid), .m1_wack_o(m1_wack), .m1_ovf_o(m1_ovf),
    .membus_read_req_o(bus_rd), .membus_write_req_o(bus_wr), .membus_addr_o(bus_a),
    .membus_data_o(bus_wd), .membus_data_i(bus_rd_dat)
  );

  typedef struct {
    logic       is_rd;
    logic       mst;
    logic [6:0] addr;
    logic [7:0] data;
  } bus_t;

  bus_t       busq[$];
  logic [7:0] rq0[$];
  logic [7:0] rq1[$];
  bus_t       mon_e;
  logic [7:0] mon_d;
  logic       slv_pend = 1'b0;
  logic [6:0] slv_addr = '0;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  // Slave memory contents as seen by a read.
  function automatic logic [7:0] slave_val(input logic [6:0] a);
    return {1'b0, a} ^ 8'h1E;
  endfunction

  // Slave + monitor. Read data is valid only in the cycle after the read
  // strobe (READ_LAT=1); other cycles present a poison value.
  always @(negedge clk) begin
    bus_rd_dat = slv_pend ? slave_val(slv_addr) : 8'hEE;
    slv_pend   = bus_rd;
    slv_addr   = bus_a;

    if (bus_rd || bus_wr) begin
      check("one_strobe", 32'(bus_rd & bus_wr), 0);
      if (busq.size() == 0) begin
        check("bus_unexpected", 1, 0);
      end else begin
        mon_e = busq.pop_front();
        check("bus_kind", 32'(bus_rd), 32'(mon_e.is_rd));
        check("bus_addr", 32'(bus_a), 32'(mon_e.addr));
        if (!mon_e.is_rd) check("bus_wdata", 32'(bus_wd), 32'(mon_e.data));
        check("wack", 32'({m1_wack, m0_wack}), mon_e.is_rd ? 0 : (mon_e.mst ? 2 : 1));
      end
    end else if (m0_wack || m1_wack) begin
      check("wack_spurious", 32'({m1_wack, m0_wack}), 0);
    end

    if (m0_rvalid) begin
      if (rq0.size() == 0) check("m0_rvalid_unexpected", 1, 0);
      else begin
        mon_d = rq0.pop_front();
        check("m0_rdata", 32'(m0_q), 32'(mon_d));
      end
    end
    if (m1_rvalid) begin
      if (rq1.size() == 0) check("m1_rvalid_unexpected", 1, 0);
      else begin
        mon_d = rq1.pop_front();
        check("m1_rdata", 32'(m1_q), 32'(mon_d));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int m, input logic rd, input logic wr,
                       input logic [6:0] a, input logic [7:0] d);
    if (m == 0) begin m0_rd = rd; m0_wr = wr; m0_a = a; m0_d = d; end
    else        begin m1_rd = rd; m1_wr = wr; m1_a = a; m1_d = d; end
  endtask

  task automatic release_all();
    m0_rd = 1'b0; m0_wr = 1'b0; m1_rd = 1'b0; m1_wr = 1'b0;
  endtask

  task automatic exp_bus(input logic is_rd, input logic mst,
                         input logic [6:0] a, input logic [7:0] d);
    bus_t e;
    e.is_rd = is_rd; e.mst = mst; e.addr = a; e.data = d;
    busq.push_back(e);
    if (is_rd) begin
      if (mst) rq1.push_back(slave_val(a));
      else     rq0.push_back(slave_val(a));
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    release_all();
    busq.delete(); rq0.delete(); rq1.delete();
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic wait_idle();
    int k = 0;
    while ((busq.size() != 0 || rq0.size() != 0 || rq1.size() != 0 || m0_busy || m1_busy) && k < 50) begin
      tick();
      k++;
    end
    if (k >= 50) check("idle_timeout", 1, 0);
    tick();
    tick();
  endtask

  initial begin
    rst = 1'b1;
    release_all();
    m0_a = '0; m0_d = '0; m1_a = '0; m1_d = '0;
    repeat (3) tick();

    // Reset state
    check("rst_busy",   32'({m1_busy, m0_busy}), 0);
    check("rst_ovf",    32'({m1_ovf, m0_ovf}), 0);
    check("rst_strobe", 32'({bus_rd, bus_wr}), 0);
    check("rst_rvalid", 32'({m1_rvalid, m0_rvalid}), 0);
    check("rst_addr",   32'(bus_a), 0);
    check("rst_rdata",  32'({m1_q, m0_q}), 0);
    rst = 1'b0;
    tick();

    // 1: m0 write, directed timing
    drive(0, 1'b0, 1'b1, 7'h10, 8'hA5);
    exp_bus(1'b0, 1'b0, 7'h10, 8'hA5);
    check("t1_busy_before", 32'(m0_busy), 0);
    tick(); release_all();
    check("t1_busy_cap", 32'(m0_busy), 1);
    check("t1_no_early_wr", 32'(bus_wr), 0);
    tick();
    check("t1_wr", 32'(bus_wr), 1);
    check("t1_addr", 32'(bus_a), 32'h10);
    check("t1_data", 32'(bus_wd), 32'hA5);
    check("t1_wack0", 32'(m0_wack), 1);
    tick();
    check("t1_wr_one_cycle", 32'(bus_wr), 0);
    check("t1_busy_after", 32'(m0_busy), 0);
    check("t1_addr_hold", 32'(bus_a), 32'h10);
    wait_idle();

    // 2: m1 read, rvalid exactly 4 cycles after the strobe
    drive(1, 1'b1, 1'b0, 7'h22, 8'h00);
    exp_bus(1'b1, 1'b1, 7'h22, 8'h00);
    tick(); release_all();
    tick();
    check("t2_rd", 32'(bus_rd), 1);
    tick();
    check("t2_rvalid_early", 32'(m1_rvalid), 0);
    tick();
    check("t2_rvalid", 32'(m1_rvalid), 1);
    check("t2_rdata", 32'(m1_q), 32'h3C);
    check("t2_m0_no_rvalid", 32'(m0_rvalid), 0);
    tick();
    check("t2_rvalid_pulse", 32'(m1_rvalid), 0);
    check("t2_rdata_hold", 32'(m1_q), 32'h3C);
    wait_idle();

    // 4: consecutive m0 strobes, second dropped
    drive(0, 1'b0, 1'b1, 7'h50, 8'h11);
    exp_bus(1'b0, 1'b0, 7'h50, 8'h11);
    tick();
    check("t4_busy", 32'(m0_busy), 1);
    drive(0, 1'b0, 1'b1, 7'h51, 8'h22);
    tick(); release_all();
    check("t4_ovf", 32'(m0_ovf), 1);
    wait_idle();
    check("t4_ovf_sticky", 32'(m0_ovf), 1);

    // Strobe during the ISSUE of its own slot is dropped
    drive(1, 1'b1, 1'b0, 7'h60, 8'h00);
    exp_bus(1'b1, 1'b1, 7'h60, 8'h00);
    tick(); release_all();
    tick();
    check("issue_rd", 32'(bus_rd), 1);
    check("issue_busy", 32'(m1_busy), 1);
    drive(1, 1'b0, 1'b1, 7'h61, 8'h77);
    tick(); release_all();
    check("issue_ovf", 32'(m1_ovf), 1);
    check("issue_busy_clr", 32'(m1_busy), 0);
    wait_idle();
    check("ovf_sticky_both", 32'({m1_ovf, m0_ovf}), 3);

    // 5: reset during WAIT of an m1 read
    do_reset();
    check("ovf_cleared", 32'({m1_ovf, m0_ovf}), 0);
    drive(1, 1'b1, 1'b0, 7'h70, 8'h00);
    exp_bus(1'b1, 1'b1, 7'h70, 8'h00);
    tick(); release_all();
    tick();
    tick();
    check("t5_in_wait", 32'({bus_rd, bus_wr}), 0);
    rst = 1'b1;
    busq.delete(); rq0.delete(); rq1.delete();
    tick();
    check("t5_no_rvalid", 32'(m1_rvalid), 0);
    tick();
    rst = 1'b0;
    check("t5_busy", 32'({m1_busy, m0_busy}), 0);
    check("t5_strobes", 32'({bus_rd, bus_wr}), 0);
    repeat (3) tick();
    drive(1, 1'b1, 1'b0, 7'h71, 8'h00);
    exp_bus(1'b1, 1'b1, 7'h71, 8'h00);
    tick(); release_all();
    wait_idle();
    check("t5_after_rdata", 32'(m1_q), 32'h6F);

    // 6: read + write strobed together -> read only
    drive(0, 1'b1, 1'b1, 7'h12, 8'h99);
    exp_bus(1'b1, 1'b0, 7'h12, 8'h00);
    tick(); release_all();
    wait_idle();

    // 3: tie arbitration alternates, starting with m0 after reset
    do_reset();
    for (int k = 0; k < 4; k++) begin
      drive(0, 1'b1, 1'b0, 7'(8'h30 + k), 8'h00);
      drive(1, 1'b1, 1'b0, 7'(8'h40 + k), 8'h00);
      exp_bus(1'b1, 1'b0, 7'(8'h30 + k), 8'h00);
      exp_bus(1'b1, 1'b1, 7'(8'h40 + k), 8'h00);
      tick(); release_all();
      wait_idle();
    end
    // After m0 alone is served, the next tie must go to m1
    drive(0, 1'b1, 1'b0, 7'h38, 8'h00);
    exp_bus(1'b1, 1'b0, 7'h38, 8'h00);
    tick(); release_all();
    wait_idle();
    drive(0, 1'b0, 1'b1, 7'h39, 8'h5A);
    drive(1, 1'b0, 1'b1, 7'h49, 8'hC3);
    exp_bus(1'b0, 1'b1, 7'h49, 8'hC3);
    exp_bus(1'b0, 1'b0, 7'h39, 8'h5A);
    tick(); release_all();
    wait_idle();

    check("end_busq_empty", 32'(busq.size()), 0);
    check("end_rq_empty", 32'(rq0.size() + rq1.size()), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
